ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 149 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with synchronised, filtered line inputs.
// Optional transfer watchdog is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned FILTER_CYCLES  = 20,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned FLT_W = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       raw, sync1_q, sync2_q, filt_q;   // bit 0 = clock, bit 1 = data
    logic [FLT_W-1:0] fcnt_q [2];
    logic             clk_prev_q;
    logic             fall, accept, in_xfer, timeout_hit;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [2:0]       bit_cnt_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic             drive_q;

    assign raw     = {ps2_data_i, ps2_clk_i};
    assign fall    = clk_prev_q & ~filt_q[0];
    assign accept  = tx_valid && (state_q == IDLE);
    assign in_xfer = (state_q == DATA) || (state_q == PARITY) ||
                     (state_q == STOP) || (state_q == ACK);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            filt_q     <= '1;
            clk_prev_q <= 1'b1;
            for (int unsigned i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            clk_prev_q <= filt_q[0];
            // a line only flips after FILTER_CYCLES consecutive samples disagree with it
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FLT_W'(FILTER_CYCLES - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FLT_W'(1);
                end
            end
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wdog_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)           wdog_q <= '0;
        else if (state_q == REQ)  wdog_q <= '0;
        else if (in_xfer)         wdog_q <= wdog_q + TO_W'(1);
    end

    // an ACK edge landing on the expiry cycle wins, keeping done/err exclusive
    assign timeout_hit = in_xfer && (wdog_q == TO_W'(TIMEOUT_CYCLES - 1)) &&
                         !((state_q == ACK) && fall);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (accept) state_d = INHIBIT;
            INHIBIT:   if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) state_d = REQ;
            REQ:       state_d = DATA;
            DATA:      if (fall && (bit_cnt_q == 3'd7)) state_d = PARITY;
            PARITY:    if (fall) state_d = STOP;
            STOP:      if (fall) state_d = ACK;
            ACK:       if (fall) state_d = WAIT_IDLE;
            WAIT_IDLE: if (filt_q == 2'b11) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (timeout_hit) state_d = WAIT_IDLE;
    end

    always_comb begin
        tx_ready    = (state_q == IDLE);
        tx_busy     = (state_q != IDLE);
        ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
        ps2_data_oe = (state_q == REQ) || (in_xfer && drive_q);
        tx_done     = (state_q == ACK) && fall && !filt_q[1];
        tx_err      = ((state_q == ACK) && fall && filt_q[1]) || timeout_hit;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            drive_q   <= 1'b0;
        end else begin
            if (accept) begin
                shift_q  <= tx_data;
                parity_q <= ~^tx_data;
            end
            inh_cnt_q <= (state_q == INHIBIT) ? inh_cnt_q + INH_W'(1) : '0;
            unique case (state_q)
                REQ: begin
                    drive_q   <= 1'b1;
                    bit_cnt_q <= '0;
                end
                DATA: if (fall) begin
                    drive_q   <= ~shift_q[0];
                    shift_q   <= {1'b0, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                PARITY: if (fall) drive_q <= ~parity_q;
                STOP:   if (fall) drive_q <= 1'b0;
                ACK:    ;
                default: drive_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a PS/2 device model.
// Define PS2_TX_TIMEOUT_EN for both files to also exercise the watchdog.
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TMO = 3000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;
    logic       dev_clk, dev_data, glitch_n;
    logic       clk_pin, data_pin;

    assign clk_pin  = dev_clk & glitch_n & ~ps2_clk_oe;
    assign data_pin = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .FILTER_CYCLES(20), .TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_i(clk_pin), .ps2_data_i(data_pin),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    typedef struct {
        logic [10:0] frame;
        bit          ack;
        bit          chk_frame;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] dev_bits;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic void push_exp(input logic [7:0] d, input logic p, input bit ack);
        exp_t e;
        e.frame     = {1'b1, p, d, 1'b0};
        e.ack       = ack;
        e.chk_frame = 1'b1;
        exp_q.push_back(e);
    endfunction

    task automatic wait_clk_oe(input logic v, input int budget);
        int n = 0;
        while (ps2_clk_oe !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (ps2_clk_oe !== v) chk("wait_clk_oe", ps2_clk_oe, v);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (tx_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_returns", tx_ready, 1);
    endtask

    task automatic send(input logic [7:0] d);
        wait_ready(3000);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // One complete device-clocked frame; samples the host's data line on each rising edge.
    task automatic dev_frame(input int glitch_after, input bit ack, input int hold11);
        logic [10:0] b;
        wait_clk_oe(1'b1, 50);
        wait_clk_oe(1'b0, INH + 100);
        repeat (50) @(negedge clk);
        b[0] = data_pin;
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            b[i] = data_pin;
            if (i == glitch_after) begin
                repeat (10) @(negedge clk);
                glitch_n = 1'b0;
                repeat (3) @(negedge clk);
                glitch_n = 1'b1;
                repeat (HALF - 13) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_bits = b;
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (30) @(negedge clk);
        dev_clk = 1'b0;
        repeat (hold11) @(negedge clk);
        if (!ack) begin
            chk("nack_waits_idle_busy", tx_busy, 1);
            chk("nack_waits_idle_ready", tx_ready, 0);
        end
        dev_clk = 1'b1;
        repeat (10) @(negedge clk);
        dev_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Scoreboard monitor: pops an expectation on every done/err pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (tx_done === 1'b1 || tx_err === 1'b1)) begin
                chk("done_err_exclusive", {tx_done, tx_err} == 2'b11, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {tx_done, tx_err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("outcome_done", tx_done, e.ack);
                    if (e.chk_frame) chk("frame_bits", dev_bits, e.frame);
                end
                @(negedge clk);
                chk("pulse_one_cycle", {tx_done, tx_err}, 0);
            end
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       p;
        bit         ack;
        int         glitch;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{d: 8'hED, p: 1'b1, ack: 1'b1, glitch: 0};
        vecs[1] = '{d: 8'h00, p: 1'b1, ack: 1'b1, glitch: 0};
        vecs[2] = '{d: 8'h07, p: 1'b0, ack: 1'b1, glitch: 0};
        vecs[3] = '{d: 8'hA5, p: 1'b1, ack: 1'b0, glitch: 0};
        vecs[4] = '{d: 8'h3C, p: 1'b1, ack: 1'b1, glitch: 3};

        rst_n = 1'b0; tx_data = '0; tx_valid = 1'b0;
        dev_clk = 1'b1; dev_data = 1'b1; glitch_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_pulses", {tx_done, tx_err}, 0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        foreach (vecs[k]) begin
            push_exp(vecs[k].d, vecs[k].p, vecs[k].ack);
            send(vecs[k].d);
            chk("busy_after_accept", tx_busy, 1);
            dev_frame(vecs[k].glitch, vecs[k].ack, vecs[k].ack ? HALF : 150);
            wait_ready(500);
        end

        // Reset in the low phase of device edge 4: nothing may be reported.
        send(8'h5A);
        wait_clk_oe(1'b1, 50);
        wait_clk_oe(1'b0, INH + 100);
        repeat (50) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i < 4) begin
                dev_clk = 1'b1;
                repeat (HALF) @(negedge clk);
            end
        end
        chk("mid_xfer_busy", tx_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_ready", tx_ready, 1);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        push_exp(8'hF4, 1'b0, 1'b1);
        send(8'hF4);
        dev_frame(0, 1'b1, HALF);
        wait_ready(500);

        // tx_valid held high across a busy transfer: the second byte waits for tx_ready.
        wait_ready(500);
        push_exp(8'h81, 1'b1, 1'b1);
        push_exp(8'h7F, 1'b0, 1'b1);
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 8'h7F;
        chk("held_valid_not_ready", tx_ready, 0);
        dev_frame(0, 1'b1, HALF);
        wait_clk_oe(1'b1, 200);
        tx_valid = 1'b0;
        dev_frame(0, 1'b1, HALF);
        wait_ready(500);

`ifdef PS2_TX_TIMEOUT_EN
        begin
            exp_t e;
            int   n = 0;
            e.frame = '0; e.ack = 1'b0; e.chk_frame = 1'b0;
            exp_q.push_back(e);
            send(8'h12);
            while (exp_q.size() != 0 && n < INH + TMO + 500) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_err_seen", exp_q.size(), 0);
            @(negedge clk);
            chk("timeout_release_oe", {ps2_clk_oe, ps2_data_oe}, 0);
            wait_ready(500);
        end
`endif

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("scoreboard_drained", exp_q.size(), 0);
        end
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
